// File: rtl/scan_bus_ctrl_pkg.sv
// Shared types and defaults for the scan-to-bus command sequencer.
package scan_pkg;

  localparam int SCAN_ADDR_W = 20;
  localparam int SCAN_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} scan_ctl_state_t;

  // Plain-vector aliases of the enum so the FSM register stays a raw logic vector
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_RSP  = RSP;
  localparam logic [1:0] S_DONE = DONE;

  typedef struct packed {
    logic                   we;
    logic [SCAN_ADDR_W-1:0] addr;
    logic [SCAN_DATA_W-1:0] wdata;
  } scan_cmd_t;

  function automatic logic is_legal_cmd(input logic wen, input logic ren);
    return wen ^ ren;
  endfunction

endpackage

// File: rtl/scan_bus_ctrl_if.sv
// Memory/control-register bus seen by the scan sequencer: request channel plus read-response channel.
interface scan_bus_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);

  logic              bus_req;
  logic              bus_gnt;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/sync_toggle_det.sv
// Synchronizes an asynchronous toggle strobe and pulses tgl for one cycle per level change.
module sync_toggle_det #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tgl
);

  logic [SYNC_STG-1:0] sync_q;
  logic                id_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      id_prev <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STG-2:0], async_in};
      id_prev <= sync_q[SYNC_STG-1];
    end
  end

  assign tgl = sync_q[SYNC_STG-1] ^ id_prev;

endmodule

// File: rtl/scan_bus_ctrl.sv
// Turns each scan_id toggle into one bus transaction and returns read data / status to the scan chain.
module scan_bus_ctrl
  import scan_pkg::*;
#(
  parameter int ADDR_W   = SCAN_ADDR_W,
  parameter int DATA_W   = SCAN_DATA_W,
  parameter int TIMEOUT  = 16,
  parameter int SYNC_STG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_id,
  input  logic              scan_wen,
  input  logic              scan_ren,
  input  logic [ADDR_W-1:0] scan_addr,
  input  logic [DATA_W-1:0] scan_wdata,
  output logic [DATA_W-1:0] scan_rdata,
  output logic              scan_ready,
  output logic              scan_err,
  scan_bus_ctrl_if.master   bus,
  output logic              busy
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]        state;
  logic [TCNT_W-1:0] tcnt;
  logic              tmo;
  logic              tgl;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  sync_toggle_det #(.SYNC_STG(SYNC_STG)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (scan_id),
    .tgl      (tgl)
  );

  assign tmo = (tcnt == TCNT_W'(TIMEOUT - 1));

  // Result registers hold their value until the next accepted toggle so the chain can capture at leisure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tcnt       <= '0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      scan_ready <= 1'b0;
      scan_err   <= 1'b0;
      scan_rdata <= '0;
    end else begin
      if (tgl && (state != S_IDLE))
        scan_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (tgl) begin
            scan_ready <= 1'b0;
            scan_err   <= 1'b0;
            scan_rdata <= '0;
            cmd_we     <= scan_wen;
            cmd_addr   <= scan_addr;
            cmd_wdata  <= scan_wdata;
            if (is_legal_cmd(scan_wen, scan_ren)) begin
              state <= S_REQ;
              tcnt  <= '0;
            end else begin
              scan_err   <= 1'b1;
              scan_ready <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (bus.bus_gnt) begin
            if (cmd_we) begin
              state <= S_DONE;
            end else if (bus.bus_rvalid) begin
              scan_rdata <= bus.bus_rdata;
              state      <= S_DONE;
            end else begin
              state <= S_RSP;
              tcnt  <= '0;
            end
          end else if (tmo) begin
            scan_err   <= 1'b1;
            scan_rdata <= '0;
            state      <= S_DONE;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        S_RSP: begin
          if (bus.bus_rvalid) begin
            scan_rdata <= bus.bus_rdata;
            state      <= S_DONE;
          end else if (tmo) begin
            scan_err   <= 1'b1;
            scan_rdata <= '0;
            state      <= S_DONE;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        default: begin
          scan_ready <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.bus_req   = (state == S_REQ);
  assign bus.bus_we    = cmd_we;
  assign bus.bus_addr  = cmd_addr;
  assign bus.bus_wdata = cmd_wdata;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_scan_bus_ctrl.sv
// Randomized scoreboard bench for scan_bus_ctrl: a bus responder model plus a result monitor fed from queues.
module tb_scan_bus_ctrl;
  import scan_pkg::*;

  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 32;
  localparam int TIMEOUT  = 16;
  localparam int SYNC_STG = 2;

  typedef struct {
    int                issue;
    int                max_lat;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  typedef struct {
    int        issue;
    scan_cmd_t cmd;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              scan_id = 1'b0;
  logic              scan_wen = 1'b0;
  logic              scan_ren = 1'b0;
  logic [ADDR_W-1:0] scan_addr = '0;
  logic [DATA_W-1:0] scan_wdata = '0;
  logic [DATA_W-1:0] scan_rdata;
  logic              scan_ready;
  logic              scan_err;
  logic              busy;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int exp_req_cnt = 0;
  int req_cnt = 0;

  int                gnt_dly = 0;
  int                rv_dly = 0;
  logic [DATA_W-1:0] rsp_data = '0;
  bit                late_rv = 1'b0;
  bit                rsp_active = 1'b0;

  rsp_t  rsp_q[$];
  beat_t beat_q[$];

  scan_bus_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  scan_bus_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .SYNC_STG(SYNC_STG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_id    (scan_id),
    .scan_wen   (scan_wen),
    .scan_ren   (scan_ren),
    .scan_addr  (scan_addr),
    .scan_wdata (scan_wdata),
    .scan_rdata (scan_rdata),
    .scan_ready (scan_ready),
    .scan_err   (scan_err),
    .bus        (bus),
    .busy       (busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportTimeout(input string name, input int waited, input int limit);
    tests++;
    fails++;
    $display("[TB] FAIL %s: waited %0d cycles, limit %0d", name, waited, limit);
  endtask

  task automatic scrambleShadow();
    scan_wen   = 1'($urandom);
    scan_ren   = 1'($urandom);
    scan_addr  = ADDR_W'($urandom);
    scan_wdata = $urandom;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || rsp_active || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) reportTimeout("wait_idle", n, 200);
    repeat (2) @(negedge clk);
  endtask

  // Issue one command and queue what the chain and bus should see, derived from the timing rules alone
  task automatic applyStimulus(input logic wen, input logic ren, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, input int g, input int r,
                               input logic [DATA_W-1:0] data, input bit ovr, input bit late,
                               input int max_lat);
    rsp_t  e;
    beat_t b;
    bit    timed_out;
    gnt_dly  = g;
    rv_dly   = r;
    rsp_data = data;
    late_rv  = late;
    @(negedge clk);
    scan_wen   = wen;
    scan_ren   = ren;
    scan_addr  = addr;
    scan_wdata = wdata;
    scan_id    = ~scan_id;
    e.issue    = cyc;
    e.max_lat  = max_lat;
    if (wen == ren) begin
      e.err   = 1'b1;
      e.rdata = '0;
    end else begin
      timed_out = (g >= TIMEOUT) || (!wen && r > TIMEOUT);
      e.err     = timed_out || ovr;
      e.rdata   = (!wen && !timed_out) ? data : '0;
      b.issue   = cyc;
      b.cmd     = '{we: wen, addr: addr, wdata: wdata};
      beat_q.push_back(b);
      exp_req_cnt++;
    end
    rsp_q.push_back(e);
    repeat (SYNC_STG + 2) @(negedge clk);
    scrambleShadow();
    if (ovr) scan_id = ~scan_id;
    waitIdle();
    checkOutput("held_ready", scan_ready, 1'b1);
    checkOutput("held_err", scan_err, e.err);
    checkOutput("held_rdata", scan_rdata, e.rdata);
  endtask

  // Monitor: compares chain-side results once the command has had time to be accepted and has finished
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_q.size() > 0 && cyc >= rsp_q[0].issue + SYNC_STG + 1) begin
        if (scan_ready && !busy) begin
          e = rsp_q.pop_front();
          checkOutput("scan_err", scan_err, e.err);
          checkOutput("scan_rdata", scan_rdata, e.rdata);
        end else if (cyc - rsp_q[0].issue > rsp_q[0].max_lat) begin
          e = rsp_q.pop_front();
          reportTimeout("scan_ready", cyc - e.issue, e.max_lat);
        end
      end
    end
  end

  // Bus slave model: grants after gnt_dly request cycles, returns read data rv_dly cycles after grant
  initial begin : responder
    int    idx;
    beat_t b;
    bus.bus_gnt    = 1'b0;
    bus.bus_rvalid = 1'b0;
    bus.bus_rdata  = $urandom;
    forever begin
      @(negedge clk);
      if (rst_n && bus.bus_req) begin
        rsp_active = 1'b1;
        req_cnt++;
        if (beat_q.size() == 0) begin
          checkOutput("unexpected_req", bus.bus_req, 1'b0);
          b.cmd = '0;
        end else begin
          b = beat_q.pop_front();
          checkOutput("req_latency", cyc, b.issue + SYNC_STG + 1);
        end
        idx = 0;
        while (bus.bus_req && idx != gnt_dly && idx < 40) begin
          @(negedge clk);
          idx++;
        end
        if (bus.bus_req && idx == gnt_dly) begin
          checkOutput("bus_we", bus.bus_we, b.cmd.we);
          checkOutput("bus_addr", bus.bus_addr, b.cmd.addr);
          checkOutput("bus_wdata", bus.bus_wdata, b.cmd.wdata);
          bus.bus_gnt = 1'b1;
          if (!b.cmd.we && rv_dly == 0) begin
            bus.bus_rvalid = 1'b1;
            bus.bus_rdata  = rsp_data;
          end
          @(negedge clk);
          bus.bus_gnt    = 1'b0;
          bus.bus_rvalid = 1'b0;
          bus.bus_rdata  = $urandom;
          checkOutput("req_after_gnt", bus.bus_req, 1'b0);
          if (!b.cmd.we && rv_dly > 0) begin
            repeat (rv_dly - 1) @(negedge clk);
            bus.bus_rvalid = 1'b1;
            bus.bus_rdata  = rsp_data;
            @(negedge clk);
            bus.bus_rvalid = 1'b0;
            bus.bus_rdata  = $urandom;
          end
        end else begin
          if (rst_n) checkOutput("req_hold_cycles", idx, TIMEOUT);
          if (late_rv) begin
            repeat (2) @(negedge clk);
            bus.bus_rvalid = 1'b1;
            bus.bus_rdata  = rsp_data;
            @(negedge clk);
            bus.bus_rvalid = 1'b0;
            bus.bus_rdata  = $urandom;
          end
        end
        rsp_active = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int   kind;
    int   g;
    int   r;
    int   n;
    bit   ovr;
    logic wen;
    logic ren;
    beat_t b;

    repeat (3) @(negedge clk);
    checkOutput("reset_bus_req", bus.bus_req, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_ready", scan_ready, 1'b0);
    checkOutput("reset_err", scan_err, 1'b0);
    checkOutput("reset_rdata", scan_rdata, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(1'b1, 1'b0, 20'h00001, 32'h87654321, 2, 0, '0, 1'b0, 1'b0, 60);
    applyStimulus(1'b0, 1'b1, 20'h00800, 32'h0, 0, 3, 32'h00001000, 1'b0, 1'b0, 20);
    applyStimulus(1'b0, 1'b1, 20'h00010, 32'h0, 100, 0, 32'hDEADBEEF, 1'b0, 1'b1, 60);
    applyStimulus(1'b1, 1'b1, 20'h00020, 32'h1, 0, 0, '0, 1'b0, 1'b0, 60);
    applyStimulus(1'b0, 1'b0, 20'h00030, 32'h2, 0, 0, '0, 1'b0, 1'b0, 60);
    applyStimulus(1'b1, 1'b0, 20'hC0040, 32'hA5A5A5A5, 10, 0, '0, 1'b1, 1'b0, 60);
    applyStimulus(1'b1, 1'b0, 20'h40050, 32'h5A5A5A5A, 1, 0, '0, 1'b0, 1'b0, 60);
    applyStimulus(1'b0, 1'b1, 20'h80060, 32'h0, 15, 16, 32'h12345678, 1'b0, 1'b0, 60);
    applyStimulus(1'b0, 1'b1, 20'h80070, 32'h0, 0, 17, 32'h0BADF00D, 1'b0, 1'b0, 60);

    // Reset while the read waits for its response
    gnt_dly  = 0;
    rv_dly   = 12;
    rsp_data = 32'hCAFEF00D;
    late_rv  = 1'b0;
    @(negedge clk);
    scan_wen  = 1'b0;
    scan_ren  = 1'b1;
    scan_addr = 20'h00090;
    scan_id   = ~scan_id;
    b.issue   = cyc;
    b.cmd     = '{we: 1'b0, addr: 20'h00090, wdata: scan_wdata};
    beat_q.push_back(b);
    exp_req_cnt++;
    repeat (SYNC_STG + 4) @(negedge clk);
    checkOutput("busy_before_reset", busy, 1'b1);
    #2;
    rst_n   = 1'b0;
    scan_id = 1'b0;
    #1;
    checkOutput("async_rst_bus_req", bus.bus_req, 1'b0);
    checkOutput("async_rst_busy", busy, 1'b0);
    checkOutput("async_rst_ready", scan_ready, 1'b0);
    checkOutput("async_rst_err", scan_err, 1'b0);
    n = 0;
    while (rsp_active && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) reportTimeout("responder_idle", n, 100);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 20'h000A0, 32'h13579BDF, 0, 0, '0, 1'b0, 1'b0, 60);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      wen  = (kind == 0) ? 1'($urandom) : (kind <= 4);
      ren  = (kind == 0) ? wen : (kind > 4);
      n    = $urandom_range(0, 9);
      g    = (n < 7) ? $urandom_range(0, 4) : (n == 7) ? 15 : (n == 8) ? 16 : $urandom_range(17, 25);
      n    = $urandom_range(0, 9);
      r    = (n < 7) ? $urandom_range(0, 4) : (n == 7) ? 16 : 17;
      ovr  = (kind != 0) && ($urandom_range(0, 4) == 0);
      if (ovr) g = $urandom_range(10, 15);
      applyStimulus(wen, ren, ADDR_W'($urandom), $urandom, g, r, $urandom, ovr,
                    1'($urandom), 60);
    end

    checkOutput("bus_req_count", req_cnt, exp_req_cnt);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, limit 30000", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
